// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative HI/LO multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2
  } mul_state_e;

  localparam int MUL_ITER_DEF = 32;
  localparam int CNT_W        = 6;

  // Magnitude of a 32-bit operand; 0x80000000 maps to unsigned 2^31.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_unit.sv
// Radix-2 shift-add multiplier feeding the architectural HI/LO registers.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; MTHI/MTLO writes accepted here
// CALC    | one shift-add step per edge, MUL_ITER edges in total
// SIGN    | apply sign to the unsigned product and commit to HI/LO
module mul_unit
  import mul_pkg::*;
#(
  parameter int MUL_ITER = MUL_ITER_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic [1:0]  hilo_we,
  input  logic [31:0] hilo_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      acc_q, acc_d;
  logic [63:0]      mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;

  logic [63:0]      acc_sum;
  logic [63:0]      product;

  assign acc_sum = acc_q + mcand_q;
  assign product = neg_q ? (~acc_q + 64'd1) : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (hilo_we[1]) hi_d = hilo_wdata;
        if (hilo_we[0]) lo_d = hilo_wdata;
        if (start && !flush) begin
          mcand_d  = {32'd0, mag32(src_a, is_signed)};
          mplier_d = mag32(src_b, is_signed);
          neg_d    = is_signed & (src_a[31] ^ src_b[31]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = ST_SIGN;
        end
      end
      ST_SIGN: begin
        state_d = ST_IDLE;
        if (!flush) begin
          {hi_d, lo_d} = product;
          done_d       = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
